game_move_ctrl: RTL and testbench

GAME_MOVE_CTRL -- requirements
Module: game_move_ctrl

---
 rtl/game_move_ctrl_pkg.sv | 45 ++++
 rtl/game_move_ctrl_arb.sv | 59 +++++
 rtl/game_move_ctrl.sv | 169 ++++++++++++++++
 tb/tb_game_move_ctrl.sv | 443 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_move_ctrl_pkg.sv
// Shared definitions for the falling-block move controller: move codes,
// block descriptor and field coordinate widths.
package game_move_ctrl_pkg;

    localparam int unsigned FIELD_X_W = 4;
    localparam int unsigned FIELD_Y_W = 5;

    typedef enum logic [2:0] {
        MOVE_APPEAR = 3'd0,
        MOVE_LEFT   = 3'd1,
        MOVE_RIGHT  = 3'd2,
        MOVE_DOWN   = 3'd3,
        MOVE_ROTATE = 3'd4
    } move_t;

    typedef struct packed {
        logic [2:0]           shape;
        logic [FIELD_X_W-1:0] x;
        logic [FIELD_Y_W-1:0] y;
        logic [1:0]           rot;
    } block_info_t;

    // Coordinates wrap modulo the field-ext width.
    function automatic logic [FIELD_X_W-1:0] add_x(input logic [FIELD_X_W-1:0] x,
                                                   input logic signed [1:0]    d);
        return x + {{(FIELD_X_W-2){d[1]}}, d};
    endfunction

    function automatic logic [FIELD_Y_W-1:0] add_y(input logic [FIELD_Y_W-1:0] y,
                                                   input logic signed [1:0]    d);
        return y + {{(FIELD_Y_W-2){d[1]}}, d};
    endfunction

    function automatic block_info_t spawn_block(input block_info_t          nb,
                                                input logic [FIELD_X_W-1:0] sx,
                                                input logic [FIELD_Y_W-1:0] sy);
        block_info_t b;
        b     = nb;
        b.x   = sx;
        b.y   = sy;
        b.rot = 2'd0;
        return b;
    endfunction

endpackage

// File: rtl/game_move_ctrl_arb.sv
// move_req_arb: pending gravity/user flags, tick-first selection and consume.
module move_req_arb
    import game_move_ctrl_pkg::*;
(
    input  logic  clk_i,
    input  logic  rst_n_i,
    input  logic  en_i,
    input  logic  clear_i,
    input  logic  consume_i,
    input  logic  tick_i,
    input  logic  user_valid_i,
    input  move_t user_move_i,
    output logic  req_any_o,
    output logic  pend_any_o,
    output move_t sel_move_o
);

    logic  r_tick_pend;
    logic  r_user_pend;
    move_t r_user_move;

    logic  w_tick_eff;
    logic  w_user_eff;
    move_t w_user_move;
    logic  w_take_tick;
    logic  w_take_user;

    // Requests arriving this cycle are visible to the selector so that a
    // tick in ARB reaches the checker on the very next cycle.
    always_comb begin
        w_tick_eff  = r_tick_pend | tick_i;
        w_user_eff  = r_user_pend | user_valid_i;
        w_user_move = r_user_pend ? r_user_move : user_move_i;
        req_any_o   = en_i & (w_tick_eff | w_user_eff);
        pend_any_o  = r_tick_pend | r_user_pend;
        sel_move_o  = w_tick_eff ? MOVE_DOWN : w_user_move;
        w_take_tick = consume_i & w_tick_eff;
        w_take_user = consume_i & ~w_tick_eff & w_user_eff;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_tick_pend <= 1'b0;
            r_user_pend <= 1'b0;
            r_user_move <= MOVE_APPEAR;
        end else if (clear_i) begin
            r_tick_pend <= 1'b0;
            r_user_pend <= 1'b0;
        end else if (en_i) begin
            // Consuming a stored flag keeps a fresh request of the same kind.
            r_tick_pend <= w_take_tick ? (r_tick_pend & tick_i) : w_tick_eff;
            r_user_pend <= w_take_user ? (r_user_pend & user_valid_i) : w_user_eff;
            if (user_valid_i) begin
                r_user_move <= user_move_i;
            end
        end
    end

endmodule

// File: rtl/game_move_ctrl.sv
// Falling-block move controller: spawns blocks, arbitrates gravity and user
// moves through an external checker, applies offsets and hands off locking.
module game_move_ctrl
    import game_move_ctrl_pkg::*;
#(
    parameter int unsigned SPAWN_X = 3,
    parameter int unsigned SPAWN_Y = 0
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              start_i,
    input  logic              user_valid_i,
    input  move_t             user_move_i,
    input  logic              tick_i,
    input  block_info_t       next_block_i,
    output logic              chk_run_o,
    output move_t             chk_move_o,
    input  logic              chk_done_i,
    input  logic              chk_can_move_i,
    input  logic signed [1:0] chk_dx_i,
    input  logic signed [1:0] chk_dy_i,
    output block_info_t       block_o,
    output logic              lock_o,
    output logic              clear_req_o,
    input  logic              clear_done_i,
    output logic              next_req_o,
    output logic              busy_o,
    output logic              game_over_o
);

    typedef enum logic [3:0] {
        IDLE,
        SPAWN,
        SPAWN_WAIT,
        ARB,
        CHECK_WAIT,
        APPLY,
        LOCK,
        CLEAR_WAIT,
        GAME_OVER
    } state_t;

    state_t      r_state;
    block_info_t r_block;
    logic        r_chk_run;
    move_t       r_chk_move;
    logic        r_lock;
    logic        r_clear_req;
    logic        r_next_req;
    logic        r_game_over;

    logic        w_en;
    logic        w_req_any;
    logic        w_pend_any;
    move_t       w_sel_move;

    assign w_en = (r_state != IDLE) && (r_state != GAME_OVER);

    move_req_arb u_arb (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .en_i         (w_en),
        .clear_i      (r_state == SPAWN),
        .consume_i    (r_state == ARB),
        .tick_i       (tick_i),
        .user_valid_i (user_valid_i),
        .user_move_i  (user_move_i),
        .req_any_o    (w_req_any),
        .pend_any_o   (w_pend_any),
        .sel_move_o   (w_sel_move)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state     <= IDLE;
            r_block     <= '0;
            r_chk_run   <= 1'b0;
            r_chk_move  <= MOVE_APPEAR;
            r_lock      <= 1'b0;
            r_clear_req <= 1'b0;
            r_next_req  <= 1'b0;
            r_game_over <= 1'b0;
        end else begin
            r_chk_run   <= 1'b0;
            r_lock      <= 1'b0;
            r_clear_req <= 1'b0;
            r_next_req  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start_i) r_state <= SPAWN;
                end
                SPAWN: begin
                    r_block    <= spawn_block(next_block_i, FIELD_X_W'(SPAWN_X),
                                              FIELD_Y_W'(SPAWN_Y));
                    r_next_req <= 1'b1;
                    r_chk_run  <= 1'b1;
                    r_chk_move <= MOVE_APPEAR;
                    r_state    <= SPAWN_WAIT;
                end
                SPAWN_WAIT: begin
                    if (chk_done_i) begin
                        if (chk_can_move_i) begin
                            r_state <= ARB;
                        end else begin
                            r_game_over <= 1'b1;
                            r_state     <= GAME_OVER;
                        end
                    end
                end
                ARB: begin
                    if (w_req_any) begin
                        r_chk_run  <= 1'b1;
                        r_chk_move <= w_sel_move;
                        r_state    <= CHECK_WAIT;
                    end
                end
                CHECK_WAIT: begin
                    // The offset is applied on the done edge so block_o moves
                    // one cycle after done; APPLY is only a pass-through.
                    if (chk_done_i) begin
                        if (chk_can_move_i) begin
                            r_block.x <= add_x(r_block.x, chk_dx_i);
                            r_block.y <= add_y(r_block.y, chk_dy_i);
                            if (r_chk_move == MOVE_ROTATE) begin
                                r_block.rot <= r_block.rot + 2'd1;
                            end
                            r_state <= APPLY;
                        end else if (r_chk_move == MOVE_DOWN) begin
                            r_lock      <= 1'b1;
                            r_clear_req <= 1'b1;
                            r_state     <= LOCK;
                        end else begin
                            r_state <= ARB;
                        end
                    end
                end
                APPLY: begin
                    r_state <= ARB;
                end
                LOCK: begin
                    r_state <= CLEAR_WAIT;
                end
                CLEAR_WAIT: begin
                    if (clear_done_i) r_state <= SPAWN;
                end
                GAME_OVER: begin
                    if (start_i) begin
                        r_game_over <= 1'b0;
                        r_state     <= SPAWN;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign chk_run_o   = r_chk_run;
    assign chk_move_o  = r_chk_move;
    assign block_o     = r_block;
    assign lock_o      = r_lock;
    assign clear_req_o = r_clear_req;
    assign next_req_o  = r_next_req;
    assign game_over_o = r_game_over;
    assign busy_o      = !((r_state == IDLE) || (r_state == GAME_OVER) ||
                           ((r_state == ARB) && !w_pend_any));

endmodule

// File: tb/tb_game_move_ctrl.sv
// Self-checking bench for game_move_ctrl with a checker/clearer emulated by
// the bench and a coordinate-level reference model of the falling block.
module tb_game_move_ctrl;
    import game_move_ctrl_pkg::*;

    localparam int unsigned SX = 3;
    localparam int unsigned SY = 0;

    logic              clk = 1'b0;
    logic              rst_n_i;
    logic              start_i;
    logic              user_valid_i;
    move_t             user_move_i;
    logic              tick_i;
    block_info_t       next_block_i;
    logic              chk_run_o;
    move_t             chk_move_o;
    logic              chk_done_i;
    logic              chk_can_move_i;
    logic signed [1:0] chk_dx_i;
    logic signed [1:0] chk_dy_i;
    block_info_t       block_o;
    logic              lock_o;
    logic              clear_req_o;
    logic              clear_done_i;
    logic              next_req_o;
    logic              busy_o;
    logic              game_over_o;

    int checks   = 0;
    int failures = 0;

    block_info_t m_blk;
    logic        m_tick;
    logic        m_user;
    move_t       m_user_mv;

    always #5 clk = ~clk;

    game_move_ctrl #(.SPAWN_X(SX), .SPAWN_Y(SY)) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n_i),
        .start_i        (start_i),
        .user_valid_i   (user_valid_i),
        .user_move_i    (user_move_i),
        .tick_i         (tick_i),
        .next_block_i   (next_block_i),
        .chk_run_o      (chk_run_o),
        .chk_move_o     (chk_move_o),
        .chk_done_i     (chk_done_i),
        .chk_can_move_i (chk_can_move_i),
        .chk_dx_i       (chk_dx_i),
        .chk_dy_i       (chk_dy_i),
        .block_o        (block_o),
        .lock_o         (lock_o),
        .clear_req_o    (clear_req_o),
        .clear_done_i   (clear_done_i),
        .next_req_o     (next_req_o),
        .busy_o         (busy_o),
        .game_over_o    (game_over_o)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic block_info_t exp_spawn(input logic [2:0] s);
        block_info_t b;
        b.shape = s;
        b.x     = FIELD_X_W'(SX);
        b.y     = FIELD_Y_W'(SY);
        b.rot   = 2'd0;
        return b;
    endfunction

    task automatic load_next(input logic [2:0] s);
        next_block_i.shape = s;
        next_block_i.x     = FIELD_X_W'($urandom);
        next_block_i.y     = FIELD_Y_W'($urandom);
        next_block_i.rot   = 2'($urandom);
    endtask

    task automatic wait_run(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (chk_run_o === 1'b1) begin
                ok = 1'b1;
                break;
            end
            cyc();
        end
    endtask

    task automatic respond(input logic can, input int vx, input int vy);
        chk_done_i     = 1'b1;
        chk_can_move_i = can;
        chk_dx_i       = vx[1:0];
        chk_dy_i       = vy[1:0];
        cyc();
        chk_done_i     = 1'b0;
        chk_can_move_i = 1'b0;
        chk_dx_i       = '0;
        chk_dy_i       = '0;
    endtask

    task automatic issue(input logic t, input logic u, input move_t mv);
        tick_i       = t;
        user_valid_i = u;
        user_move_i  = mv;
        cyc();
        tick_i       = 1'b0;
        user_valid_i = 1'b0;
    endtask

    task automatic clear_and_respawn(input logic [2:0] s);
        cyc();
        repeat ($urandom_range(0, 2)) cyc();
        load_next(s);
        clear_done_i = 1'b1;
        cyc();
        clear_done_i = 1'b0;
    endtask

    function automatic move_t apply_move(input move_t mv, input int vx, input int vy);
        m_blk.x = FIELD_X_W'(int'(m_blk.x) + vx);
        m_blk.y = FIELD_Y_W'(int'(m_blk.y) + vy);
        if (mv == MOVE_ROTATE) m_blk.rot = 2'((int'(m_blk.rot) + 1) % 4);
        return mv;
    endfunction

    task automatic test_reset();
        rst_n_i = 1'b0; start_i = 1'b0; user_valid_i = 1'b0; user_move_i = MOVE_APPEAR;
        tick_i = 1'b0; chk_done_i = 1'b0; chk_can_move_i = 1'b0; chk_dx_i = '0;
        chk_dy_i = '0; clear_done_i = 1'b0; load_next(3'd0);
        cyc(); cyc();
        checks++;
        if (block_o !== '0 || chk_move_o !== MOVE_APPEAR) begin
            failures++;
            $display("FAIL reset_block got=%h/%0d exp=0/%0d", block_o, chk_move_o, MOVE_APPEAR);
        end
        checks++;
        if ({chk_run_o, lock_o, clear_req_o, next_req_o, game_over_o, busy_o} !== 6'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=000000",
                     {chk_run_o, lock_o, clear_req_o, next_req_o, game_over_o, busy_o});
        end
        rst_n_i = 1'b1;
        cyc();
    endtask

    task automatic test_spawn();
        logic [2:0] s;
        s = 3'($urandom_range(0, 6));
        load_next(s);
        start_i = 1'b1; cyc(); start_i = 1'b0; cyc();
        checks++;
        if (next_req_o !== 1'b1 || chk_run_o !== 1'b1 || chk_move_o !== MOVE_APPEAR) begin
            failures++;
            $display("FAIL spawn_pulses got=next%b run%b mv%0d exp=next1 run1 mv0",
                     next_req_o, chk_run_o, chk_move_o);
        end
        checks++;
        if (block_o !== exp_spawn(s)) begin
            failures++;
            $display("FAIL spawn_block got=%h exp=%h", block_o, exp_spawn(s));
        end
        respond(1'b1, 0, 0);
        checks++;
        if (busy_o !== 1'b0 || chk_run_o !== 1'b0) begin
            failures++;
            $display("FAIL spawn_idle_arb got=busy%b run%b exp=busy0 run0", busy_o, chk_run_o);
        end
        m_blk = exp_spawn(s);
    endtask

    task automatic test_move();
        bit ok;
        issue(1'b0, 1'b1, MOVE_LEFT);
        checks++;
        if (chk_run_o !== 1'b1 || chk_move_o !== MOVE_LEFT) begin
            failures++;
            $display("FAIL left_issue got=run%b mv%0d exp=run1 mv%0d", chk_run_o, chk_move_o, MOVE_LEFT);
        end
        respond(1'b1, -1, 0);
        void'(apply_move(MOVE_LEFT, -1, 0));
        checks++;
        if (block_o.x !== FIELD_X_W'(2) || block_o !== m_blk) begin
            failures++;
            $display("FAIL left_apply got=%h exp=%h (x=2)", block_o, m_blk);
        end
        cyc();
        for (int k = 0; k < 4; k++) begin
            issue(1'b0, 1'b1, MOVE_ROTATE);
            wait_run(ok);
            respond(1'b1, 0, 0);
            void'(apply_move(MOVE_ROTATE, 0, 0));
            checks++;
            if (!ok || block_o !== m_blk) begin
                failures++;
                $display("FAIL rotate_%0d got=ok%0d %h exp=%h", k, ok, block_o, m_blk);
            end
            cyc();
        end
        checks++;
        if (block_o.rot !== 2'd0) begin
            failures++;
            $display("FAIL rot_wrap got=%0d exp=0", block_o.rot);
        end
    endtask

    task automatic test_priority();
        bit ok;
        issue(1'b1, 1'b1, MOVE_RIGHT);
        checks++;
        if (chk_run_o !== 1'b1 || chk_move_o !== MOVE_DOWN) begin
            failures++;
            $display("FAIL prio_first got=run%b mv%0d exp=run1 mv%0d", chk_run_o, chk_move_o, MOVE_DOWN);
        end
        respond(1'b1, 0, 1);
        void'(apply_move(MOVE_DOWN, 0, 1));
        checks++;
        if (block_o !== m_blk) begin
            failures++;
            $display("FAIL prio_down_apply got=%h exp=%h", block_o, m_blk);
        end
        wait_run(ok);
        checks++;
        if (!ok || chk_move_o !== MOVE_RIGHT) begin
            failures++;
            $display("FAIL prio_second got=ok%0d mv%0d exp=ok1 mv%0d", ok, chk_move_o, MOVE_RIGHT);
        end
        respond(1'b1, 1, 0);
        void'(apply_move(MOVE_RIGHT, 1, 0));
        checks++;
        if (block_o !== m_blk) begin
            failures++;
            $display("FAIL prio_right_apply got=%h exp=%h", block_o, m_blk);
        end
        cyc();
    endtask

    task automatic test_lock();
        bit ok;
        logic [2:0] s;
        issue(1'b1, 1'b0, MOVE_APPEAR);
        wait_run(ok);
        respond(1'b0, 0, 1);
        checks++;
        if (!ok || lock_o !== 1'b1 || clear_req_o !== 1'b1) begin
            failures++;
            $display("FAIL lock_pulse got=ok%0d lock%b clr%b exp=ok1 lock1 clr1", ok, lock_o, clear_req_o);
        end
        cyc();
        checks++;
        if (lock_o !== 1'b0 || clear_req_o !== 1'b0 || chk_run_o !== 1'b0) begin
            failures++;
            $display("FAIL lock_width got=lock%b clr%b run%b exp=000", lock_o, clear_req_o, chk_run_o);
        end
        s = 3'($urandom_range(0, 6));
        clear_and_respawn(s);
        wait_run(ok);
        checks++;
        if (!ok || next_req_o !== 1'b1 || chk_move_o !== MOVE_APPEAR || block_o !== exp_spawn(s)) begin
            failures++;
            $display("FAIL respawn got=ok%0d next%b mv%0d %h exp=ok1 next1 mv0 %h",
                     ok, next_req_o, chk_move_o, block_o, exp_spawn(s));
        end
        respond(1'b1, 0, 0);
        m_blk = exp_spawn(s);
    endtask

    task automatic test_random();
        bit ok;
        bit stable;
        logic do_t, do_u, can;
        move_t mv, expm;
        int vx, vy;
        logic [2:0] s;
        m_tick = 1'b0;
        m_user = 1'b0;
        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 2))
                0:       begin do_t = 1'b1; do_u = 1'b0; end
                1:       begin do_t = 1'b0; do_u = 1'b1; end
                default: begin do_t = 1'b1; do_u = 1'b1; end
            endcase
            mv = move_t'($urandom_range(1, 4));
            issue(do_t, do_u, mv);
            if (do_t) m_tick = 1'b1;
            if (do_u) begin m_user = 1'b1; m_user_mv = mv; end
            while (m_tick || m_user) begin
                if (m_tick) begin expm = MOVE_DOWN; m_tick = 1'b0; end
                else begin expm = m_user_mv; m_user = 1'b0; end
                wait_run(ok);
                checks++;
                if (!ok || chk_move_o !== expm) begin
                    failures++;
                    $display("FAIL rnd_issue it=%0d got=ok%0d mv%0d exp=ok1 mv%0d", it, ok, chk_move_o, expm);
                    if (!ok) return;
                end
                stable = 1'b1;
                repeat ($urandom_range(0, 3)) begin
                    cyc();
                    if (chk_run_o !== 1'b0 || chk_move_o !== expm) stable = 1'b0;
                end
                checks++;
                if (!stable) begin
                    failures++;
                    $display("FAIL rnd_hold it=%0d got=run%b mv%0d exp=run0 mv%0d", it, chk_run_o, chk_move_o, expm);
                end
                can = ($urandom_range(0, 3) != 0);
                vx  = int'($urandom_range(0, 2)) - 1;
                vy  = int'($urandom_range(0, 2)) - 1;
                respond(can, vx, vy);
                if (can) begin
                    void'(apply_move(expm, vx, vy));
                    checks++;
                    if (block_o !== m_blk) begin
                        failures++;
                        $display("FAIL rnd_apply it=%0d got=%h exp=%h", it, block_o, m_blk);
                    end
                    cyc();
                end else if (expm == MOVE_DOWN) begin
                    checks++;
                    if (lock_o !== 1'b1 || clear_req_o !== 1'b1) begin
                        failures++;
                        $display("FAIL rnd_lock it=%0d got=lock%b clr%b exp=11", it, lock_o, clear_req_o);
                    end
                    m_tick = 1'b0;
                    m_user = 1'b0;
                    s = 3'($urandom_range(0, 6));
                    clear_and_respawn(s);
                    wait_run(ok);
                    checks++;
                    if (!ok || chk_move_o !== MOVE_APPEAR || block_o !== exp_spawn(s)) begin
                        failures++;
                        $display("FAIL rnd_spawn it=%0d got=ok%0d mv%0d %h exp=%h", it, ok, chk_move_o, block_o, exp_spawn(s));
                        if (!ok) return;
                    end
                    respond(1'b1, 0, 0);
                    m_blk = exp_spawn(s);
                end else begin
                    checks++;
                    if (block_o !== m_blk || lock_o !== 1'b0) begin
                        failures++;
                        $display("FAIL rnd_reject it=%0d got=%h lock%b exp=%h lock0", it, block_o, lock_o, m_blk);
                    end
                end
            end
        end
    endtask

    task automatic test_game_over();
        bit ok;
        int runs;
        logic [2:0] s;
        issue(1'b1, 1'b0, MOVE_APPEAR);
        wait_run(ok);
        respond(1'b0, 0, 0);
        s = 3'($urandom_range(0, 6));
        clear_and_respawn(s);
        wait_run(ok);
        respond(1'b0, 0, 0);
        checks++;
        if (!ok || game_over_o !== 1'b1 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL game_over got=ok%0d go%b busy%b exp=ok1 go1 busy0", ok, game_over_o, busy_o);
        end
        runs = 0;
        for (int i = 0; i < 12; i++) begin
            issue(1'($urandom), 1'($urandom), move_t'($urandom_range(1, 4)));
            if (chk_run_o === 1'b1) runs++;
        end
        checks++;
        if (runs != 0 || block_o !== exp_spawn(s)) begin
            failures++;
            $display("FAIL go_quiet got=runs%0d %h exp=runs0 %h", runs, block_o, exp_spawn(s));
        end
        s = 3'($urandom_range(0, 6));
        load_next(s);
        start_i = 1'b1; cyc(); start_i = 1'b0;
        checks++;
        if (game_over_o !== 1'b0) begin
            failures++;
            $display("FAIL go_clear got=%b exp=0", game_over_o);
        end
        wait_run(ok);
        checks++;
        if (!ok || next_req_o !== 1'b1 || chk_move_o !== MOVE_APPEAR || block_o !== exp_spawn(s)) begin
            failures++;
            $display("FAIL go_restart got=ok%0d next%b %h exp=%h", ok, next_req_o, block_o, exp_spawn(s));
        end
        respond(1'b1, 0, 0);
        m_blk = exp_spawn(s);
    endtask

    task automatic test_reset_midcheck();
        bit ok;
        int runs;
        issue(1'b0, 1'b1, MOVE_RIGHT);
        wait_run(ok);
        rst_n_i = 1'b0; cyc(); rst_n_i = 1'b1;
        respond(1'b1, 1, 1);
        checks++;
        if (!ok || block_o !== '0 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL late_done got=ok%0d %h busy%b exp=ok1 0 busy0", ok, block_o, busy_o);
        end
        clear_done_i = 1'b1; cyc(); clear_done_i = 1'b0;
        runs = 0;
        for (int i = 0; i < 6; i++) begin
            issue(1'b1, 1'b1, MOVE_LEFT);
            if (chk_run_o === 1'b1 || next_req_o === 1'b1 || busy_o !== 1'b0) runs++;
        end
        checks++;
        if (runs != 0 || block_o !== '0) begin
            failures++;
            $display("FAIL idle_quiet got=act%0d %h exp=act0 0", runs, block_o);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_spawn();
        test_move();
        test_priority();
        test_lock();
        test_random();
        test_game_over();
        test_reset_midcheck();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
